// File: rtl/clk_gate_ctrl.sv
// Per-domain clock-gating controller: gates idle domains, re-enables on activity, flags ready after WAKE_LAT.
// Optional per-domain gated-cycle counters are built when CLK_GATE_STATS_EN is defined.

module clk_gate_dom #(
  parameter int IDLE_W   = 8,
  parameter int WAKE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDLE_W-1:0] idle_thresh_i,
  input  logic              act_i,
  output logic              en_o,
  output logic              rdy_o
);
  typedef enum logic [1:0] {RUN, GATED, WAKE} state_t;

  localparam int WC_W = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'((WAKE_LAT > 0) ? WAKE_LAT - 1 : 0);

  state_t            state_q, state_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [WC_W-1:0]   wc_q, wc_d;
  logic              en_q, en_d, rdy_q, rdy_d;
  logic [IDLE_W:0]   idle_inc;
  logic [IDLE_W-1:0] idle_sat;

  // One extra bit so the threshold compare sees idle_cnt+1 even when the counter is saturated.
  assign idle_inc = {1'b0, idle_q} + 1'b1;
  assign idle_sat = idle_inc[IDLE_W] ? '1 : idle_inc[IDLE_W-1:0];

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    wc_d    = wc_q;
    en_d    = en_q;
    rdy_d   = rdy_q;
    case (state_q)
      RUN: begin
        if (act_i) begin
          idle_d = '0;
        end else if ((idle_thresh_i != '0) && (idle_inc >= {1'b0, idle_thresh_i})) begin
          state_d = GATED;
          idle_d  = '0;
          en_d    = 1'b0;
          rdy_d   = 1'b0;
        end else begin
          idle_d = idle_sat;
        end
      end
      GATED: begin
        if (act_i) begin
          en_d = 1'b1;
          wc_d = '0;
          if (WAKE_LAT == 0) begin
            state_d = RUN;
            rdy_d   = 1'b1;
          end else begin
            state_d = WAKE;
          end
        end
      end
      WAKE: begin
        // Not abortable: completes regardless of activity.
        if (wc_q == WC_LAST) begin
          state_d = RUN;
          rdy_d   = 1'b1;
          idle_d  = '0;
          wc_d    = '0;
        end else begin
          wc_d = wc_q + 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        en_d    = 1'b1;
        rdy_d   = 1'b1;
        idle_d  = '0;
        wc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      idle_q  <= '0;
      wc_q    <= '0;
      en_q    <= 1'b1;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      wc_q    <= wc_d;
      en_q    <= en_d;
      rdy_q   <= rdy_d;
    end
  end

  assign en_o  = en_q;
  assign rdy_o = rdy_q;
endmodule

module clk_gate_ctrl #(
  parameter int N_DOM    = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_LAT = 2
`ifdef CLK_GATE_STATS_EN
  , parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDLE_W-1:0] idle_thresh,
  input  logic [N_DOM-1:0]  force_on,
  input  logic [N_DOM-1:0]  busy,
  input  logic [N_DOM-1:0]  wake_req,
`ifdef CLK_GATE_STATS_EN
  input  logic              stats_clr,
  output logic [N_DOM*CNT_W-1:0] gated_cnt,
`endif
  output logic [N_DOM-1:0]  enable,
  output logic [N_DOM-1:0]  ready
);
  logic [N_DOM-1:0] act;
  assign act = busy | wake_req | force_on;

  clk_gate_dom #(.IDLE_W(IDLE_W), .WAKE_LAT(WAKE_LAT)) u_dom [N_DOM-1:0] (
    .clk           (clk),
    .rst           (rst),
    .idle_thresh_i (idle_thresh),
    .act_i         (act),
    .en_o          (enable),
    .rdy_o         (ready)
  );

`ifdef CLK_GATE_STATS_EN
  logic [N_DOM-1:0][CNT_W-1:0] gcnt_q;

  for (genvar d = 0; d < N_DOM; d++) begin : g_stats
    always_ff @(posedge clk) begin
      if (rst || stats_clr) gcnt_q[d] <= '0;
      else if (!enable[d] && (gcnt_q[d] != '1)) gcnt_q[d] <= gcnt_q[d] + 1'b1;
    end
    assign gated_cnt[d*CNT_W +: CNT_W] = gcnt_q[d];
  end
`endif
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed self-checking bench for clk_gate_ctrl (N_DOM=4, IDLE_W=8, WAKE_LAT=2).
module tb_clk_gate_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] idle_thresh;
  logic [3:0] force_on, busy, wake_req, enable, ready;
`ifdef CLK_GATE_STATS_EN
  logic        stats_clr;
  logic [63:0] gated_cnt;
  logic [15:0] gated_cnt_s;
  logic [3:0]  enable_s, ready_s;
`endif
  int errs = 0, checks = 0;

  clk_gate_ctrl #(.N_DOM(4), .IDLE_W(8), .WAKE_LAT(2)) dut (
    .clk(clk), .rst(rst), .idle_thresh(idle_thresh), .force_on(force_on),
    .busy(busy), .wake_req(wake_req),
`ifdef CLK_GATE_STATS_EN
    .stats_clr(stats_clr), .gated_cnt(gated_cnt),
`endif
    .enable(enable), .ready(ready));

`ifdef CLK_GATE_STATS_EN
  clk_gate_ctrl #(.N_DOM(4), .IDLE_W(8), .WAKE_LAT(2), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .idle_thresh(idle_thresh), .force_on(force_on),
    .busy(busy), .wake_req(wake_req), .stats_clr(stats_clr), .gated_cnt(gated_cnt_s),
    .enable(enable_s), .ready(ready_s));
`endif

  always #5 clk = ~clk;

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // All busy long enough that any gated domain has woken and every idle count is 0.
  task automatic settle();
    busy = 4'hF; wake_req = 4'h0; force_on = 4'h0; idle_thresh = 8'd3;
    tick(4);
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_thresh = 8'd0; busy = 4'h0; wake_req = 4'h0; force_on = 4'h0;
`ifdef CLK_GATE_STATS_EN
    stats_clr = 1'b0;
`endif
    tick(2);
    rst = 1'b0;
    checks++; if (enable !== 4'hF) begin errs++; $display("FAIL reset_enable got=%h exp=F", enable); end
    checks++; if (ready !== 4'hF) begin errs++; $display("FAIL reset_ready got=%h exp=F", ready); end
`ifdef CLK_GATE_STATS_EN
    checks++; if (gated_cnt !== 64'd0) begin errs++; $display("FAIL reset_cnt got=%h exp=0", gated_cnt); end
`endif
    tick(100);
    checks++; if (enable !== 4'hF) begin errs++; $display("FAIL thresh0_enable got=%h exp=F", enable); end
    checks++; if (ready !== 4'hF) begin errs++; $display("FAIL thresh0_ready got=%h exp=F", ready); end
  endtask

  task automatic test_gating();
    logic exp;
    settle();
    busy = 4'hE;
    for (int t = 0; t <= 4; t++) begin
      exp = (t < 3);
      checks++; if (enable[0] !== exp) begin errs++; $display("FAIL gate t=%0d enable0=%b exp=%b", t, enable[0], exp); end
      tick();
    end
    settle();
    for (int t = 0; t <= 6; t++) begin
      busy = (t == 1) ? 4'hF : 4'hE;
      exp = (t < 5);
      checks++; if (enable[0] !== exp) begin errs++; $display("FAIL gate_restart t=%0d enable0=%b exp=%b", t, enable[0], exp); end
      tick();
    end
  endtask

  task automatic test_wake();
    logic ee, er;
    settle();
    for (int t = 0; t <= 30; t++) begin
      wake_req = (t == 20) ? 4'b0010 : 4'b0000;
      busy     = (t >= 21) ? 4'hF : 4'b1101;
      ee = (t < 3) || (t >= 21);
      er = (t < 3) || (t >= 23);
      checks++; if (enable[1] !== ee) begin errs++; $display("FAIL wake_en t=%0d got=%b exp=%b", t, enable[1], ee); end
      checks++; if (ready[1] !== er) begin errs++; $display("FAIL wake_rdy t=%0d got=%b exp=%b", t, ready[1], er); end
      tick();
    end
  endtask

  task automatic test_collision_force();
    logic ee, er;
    settle();
    for (int t = 0; t <= 6; t++) begin
      busy     = 4'b1011;
      wake_req = (t == 2) ? 4'b0100 : 4'b0000;
      ee = (t < 6);
      checks++; if (enable[2] !== ee) begin errs++; $display("FAIL collide t=%0d enable2=%b exp=%b", t, enable[2], ee); end
      tick();
    end
    settle();
    for (int t = 0; t <= 20; t++) begin
      busy     = 4'b0111;
      force_on = (t >= 5) ? 4'b1000 : 4'b0000;
      ee = (t < 3) || (t >= 6);
      er = (t < 3) || (t >= 8);
      checks++; if (enable[3] !== ee) begin errs++; $display("FAIL force_en t=%0d got=%b exp=%b", t, enable[3], ee); end
      checks++; if (ready[3] !== er) begin errs++; $display("FAIL force_rdy t=%0d got=%b exp=%b", t, ready[3], er); end
      tick();
    end
    force_on = 4'h0;
  endtask

  task automatic test_reset_mid_wake();
    settle();
    // Domains 1 and 2 gate at t=3; domain 1 woken at t=5, reset during its first WAKE cycle.
    for (int t = 0; t <= 6; t++) begin
      busy     = 4'b1001;
      wake_req = (t == 5) ? 4'b0010 : 4'b0000;
      rst      = (t == 6);
      tick();
    end
    rst = 1'b0; wake_req = 4'h0;
    checks++; if (enable !== 4'hF) begin errs++; $display("FAIL rst_wake_en got=%h exp=F", enable); end
    checks++; if (ready !== 4'hF) begin errs++; $display("FAIL rst_wake_rdy got=%h exp=F", ready); end

    settle();
    idle_thresh = 8'd10;
    busy = 4'hE;
    tick(5);
    checks++; if (enable[0] !== 1'b1) begin errs++; $display("FAIL live_pre got=%b exp=1", enable[0]); end
    idle_thresh = 8'd2;
    tick();
    checks++; if (enable[0] !== 1'b0) begin errs++; $display("FAIL live_drop got=%b exp=0", enable[0]); end
  endtask

`ifdef CLK_GATE_STATS_EN
  task automatic test_stats();
    settle();
    stats_clr = 1'b1; tick(); stats_clr = 1'b0;
    checks++; if (gated_cnt !== 64'd0) begin errs++; $display("FAIL stats_clr0 got=%h exp=0", gated_cnt); end
    busy = 4'hE;
    tick(53);
    checks++; if (gated_cnt[15:0] !== 16'd50) begin errs++; $display("FAIL stats_50 got=%0d exp=50", gated_cnt[15:0]); end
    checks++; if (gated_cnt_s[3:0] !== 4'd15) begin errs++; $display("FAIL stats_sat got=%0d exp=15", gated_cnt_s[3:0]); end
    stats_clr = 1'b1; busy = 4'hF;
    tick();
    stats_clr = 1'b0;
    checks++; if (gated_cnt[15:0] !== 16'd0) begin errs++; $display("FAIL stats_clr_pri got=%0d exp=0", gated_cnt[15:0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_gating();
    test_wake();
    test_collision_force();
    test_reset_mid_wake();
`ifdef CLK_GATE_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/clk_gate_ctrl.md
Name: clk_gate_ctrl

Overview:
Per-domain clock-gating controller that drives the `enable` inputs of a bank of GatedClk cells, one cell per clock domain.
- Watches each domain's activity and gates it off after a programmable number of consecutive idle cycles.
- Re-enables the domain on a wake request and signals `ready` once the restarted clock has settled.
- Sits in the clock/power-management block, between the unit busy/wake signals and the GatedClk instances.

Parameters:
N_DOM, 4, number of independently gated domains
IDLE_W, 8, width of idle threshold and idle counter
WAKE_LAT, 2, cycles from enable rise to ready rise (0 allowed)
CNT_W, 16, width of per-domain gated-cycle counter (optional feature only)

Ports:
clk  input  1  free-running ungated clock
rst  input  1  synchronous active-high reset
idle_thresh  input  IDLE_W  consecutive idle cycles before gating; 0 = gating disabled (all domains stay RUN)
force_on  input  N_DOM  per-domain hold-enabled; counts as activity
busy  input  N_DOM  domain is working; counts as activity
wake_req  input  N_DOM  request to run domain; counts as activity
enable  output  N_DOM  registered; drives GatedClk.enable
ready  output  N_DOM  registered; domain clock running and stable
stats_clr  input  1  clear gated counters (feature only)
gated_cnt  output  N_DOM*CNT_W  gated-cycle counters, domain d at [d*CNT_W +: CNT_W] (feature only)

Behaviour:
- Domains fully independent; each has an FSM {RUN, GATED, WAKE}, a saturating idle_cnt[IDLE_W] and a wake counter.
- Idle definition: idle[d] = !busy[d] & !wake_req[d] & !force_on[d].
- Reset:
  - rst sampled at posedge; state=RUN, enable=all 1, ready=all 1, idle_cnt=0, wake cnt=0.
  - rst has priority over all events; mid-WAKE or mid-GATED it returns to RUN at the next edge and skips WAKE_LAT.
- RUN (enable=1, ready=1):
  - Non-idle cycle: idle_cnt<=0.
  - Idle cycle: idle_cnt<=sat(idle_cnt+1).
  - If idle && idle_thresh!=0 && idle_cnt+1 >= idle_thresh: go to GATED; enable and ready fall in the next cycle.
  - Net effect: gated in the cycle after the idle_thresh-th consecutive idle cycle.
  - Comparison uses the live idle_thresh. Lowering it below the current idle_cnt gates on the next idle cycle. Setting it to 0 never gates.
- GATED (enable=0, ready=0):
  - Any non-idle cycle → WAKE; enable=1 from the next cycle, wake cnt=0.
  - If WAKE_LAT==0, go directly to RUN instead, with enable=ready=1 in the next cycle.
- WAKE (enable=1, ready=0):
  - Wake cnt increments each cycle; after WAKE_LAT cycles in WAKE → RUN with ready=1 and idle_cnt=0.
  - Wake is not abortable: dropping wake_req during WAKE still completes to RUN.
- Wake latency: activity in GATED at cycle t → enable=1 at t+1 → ready=1 at t+1+WAKE_LAT.
- Simultaneous events: activity in the same cycle the threshold would be reached → stays RUN, idle_cnt<=0.
- Outputs come straight from flops, so enable is glitch-free into GatedClk. Scan override stays inside GatedClk and is not handled here.

Optional Feature:
CLK_GATE_STATS_EN
- Defined: each domain has a CNT_W counter that increments every cycle enable[d]==0 and saturates at all-ones. rst or stats_clr clears all counters; clear has priority over increment. The stats_clr and gated_cnt ports exist.
- Not defined: no counters, and stats_clr and gated_cnt are absent from the port list. FSM behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles, release → enable=4'hF, ready=4'hF, counters 0; hold all idle with thresh=0 for 100 cycles → enable stays 4'hF.
- Gating: thresh=3, domain 0 idle from cycle 0 → enable[0]=1 cycles 0-2, enable[0]=0 from cycle 3; busy pulse at cycle 1 restarts the count → enable[0] falls at cycle 5.
- Wake: WAKE_LAT=2, domain 1 gated, wake_req[1] one-cycle pulse at t=20 → enable[1]=1 at t=21, ready[1]=1 at t=23 and stays high.
- Collision/force: wake_req[2] asserted in the threshold cycle → no gating; force_on[3]=1 while GATED → wakes, and stays RUN while held.
- Reset mid-wake: rst at WAKE cycle 1 → next cycle enable=1, ready=1, state RUN; live threshold drop from 10 to 2 with idle_cnt=5 → gated on next idle cycle.
- Stats (CLK_GATE_STATS_EN): domain gated 50 cycles → gated_cnt=50; stats_clr in the same cycle as an increment → 0; CNT_W=4 with 20 gated cycles → saturates at 15.
